// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline hazard/forwarding controller.
//   - opcode values, instruction field positions
//   - forwarding-mux source encodings
//   - slot_t: per-stage destination tracking {v, rd, ld}
// Related build option: PIPE_FWD_EN (see pipe_hazard_ctrl.sv).
package pipe_pkg;

    // Opcodes that touch the register file; 100-111 are NOPs.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ALU = 3'b010;
    localparam logic [2:0] OP_LD  = 3'b011;

    // Instruction field slices.
    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 29;
    localparam int unsigned RS1_HI = 28;
    localparam int unsigned RS1_LO = 25;
    localparam int unsigned RS2_HI = 24;
    localparam int unsigned RS2_LO = 21;
    localparam int unsigned RD_HI  = 20;
    localparam int unsigned RD_LO  = 17;

    // Register index width as encoded in the instruction word.
    localparam int unsigned REG_W = 4;

    // EX operand mux source encodings.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXM = 2'd1;
    localparam logic [1:0] FWD_MWB = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // One tracked pipeline slot. v means "valid and writes rd".
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } slot_t;

    // Opcode reads rs1.
    function automatic logic op_reads_rs1(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ALU) || (op == OP_LD);
    endfunction

    // Opcode reads rs2 (LOAD only uses rs1 as the address).
    function automatic logic op_reads_rs2(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ALU);
    endfunction

    // Every register-reading opcode also writes rd.
    function automatic logic op_writes(input logic [2:0] op);
        return op_reads_rs1(op);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decoder/datapath <-> hazard controller signal bundle.
//   id_valid, id_instr   : instruction presented in ID (driven by master)
//   stall                : hold PC and IF/ID, bubble into EX
//   fwd_a, fwd_b         : EX operand mux selects
//   wb_we, wb_rd         : regfile write strobe and address for the WB instruction
//   stall_cnt            : saturating stall-cycle counter
// Modports: master = decoder/datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned RW    = 4,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [31:0]      id_instr;
    logic             stall;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             wb_we;
    logic [RW-1:0]    wb_rd;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_instr,
        input  stall, fwd_a, fwd_b, wb_we, wb_rd, stall_cnt
    );

    modport slave (
        input  id_valid, id_instr,
        output stall, fwd_a, fwd_b, wb_we, wb_rd, stall_cnt
    );

endinterface

// File: rtl/pipe_src_match.sv
// pipe_src_match: compares one ID source register against the EX/MEM/WB slots.
//   used     in  the opcode in ID actually reads this source
//   src      in  source register index
//   ex/mem/wb in tracked slots
//   hit_ex   out producer in EX
//   hit_mem  out producer in MEM
//   hit_wb   out producer in WB (forced 0 when the regfile writes through)
//   fwd      out operand mux code, youngest producer wins
module pipe_src_match
    import pipe_pkg::*;
#(
    parameter int unsigned WR_THRU = 0
) (
    input  logic             used,
    input  logic [REG_W-1:0] src,
    input  slot_t            ex,
    input  slot_t            mem,
    input  slot_t            wb,
    output logic             hit_ex,
    output logic             hit_mem,
    output logic             hit_wb,
    output logic [1:0]       fwd
);

    logic unused_ld;
    assign unused_ld = ^{ex.ld, mem.ld, wb.ld};

    always_comb begin
        hit_ex  = used & ex.v  & (ex.rd  == src);
        hit_mem = used & mem.v & (mem.rd == src);
        // With write-through the regfile read already sees the WB value.
        hit_wb  = used & (WR_THRU == 0) & wb.v & (wb.rd == src);

        fwd = FWD_RF;
        if (hit_ex) begin
            fwd = FWD_EXM;
        end else if (hit_mem) begin
            fwd = FWD_MWB;
        end else if (hit_wb) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard and forwarding control for the ID/EX/MEM/WB core.
// Tracks the destination of every in-flight instruction, stalls ID on hazards,
// drives the regfile write strobe and (optionally) the EX operand muxes.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of pipe_hazard_ctrl_if (id_valid/id_instr in;
//        stall, fwd_a, fwd_b, wb_we, wb_rd, stall_cnt out)
// Build option:
//   PIPE_FWD_EN defined   : forwarding used, only load-use stalls
//   PIPE_FWD_EN undefined : fwd_a/b = 0, every RAW hazard stalls until the
//                           producer leaves the tracked window
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned NREG    = 16,
    parameter int unsigned RW      = $clog2(NREG),
    parameter int unsigned WR_THRU = 0,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]       op;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic             use1, use2, writes;

    logic             h1_ex, h1_mem, h1_wb;
    logic             h2_ex, h2_mem, h2_wb;
    logic [1:0]       f1, f2;

    logic             hazard;
    logic             stall;
    logic             issue;
    logic             unused_cfg;

    // Decode the ID instruction.
    always_comb begin
        op     = bus.id_instr[OP_HI:OP_LO];
        rs1    = bus.id_instr[RS1_HI:RS1_LO];
        rs2    = bus.id_instr[RS2_HI:RS2_LO];
        rd     = bus.id_instr[RD_HI:RD_LO];
        use1   = op_reads_rs1(op);
        use2   = op_reads_rs2(op);
        writes = op_writes(op);
    end

    pipe_src_match #(
        .WR_THRU (WR_THRU)
    ) u_match_rs1 (
        .used    (use1),
        .src     (rs1),
        .ex      (ex_q),
        .mem     (mem_q),
        .wb      (wb_q),
        .hit_ex  (h1_ex),
        .hit_mem (h1_mem),
        .hit_wb  (h1_wb),
        .fwd     (f1)
    );

    pipe_src_match #(
        .WR_THRU (WR_THRU)
    ) u_match_rs2 (
        .used    (use2),
        .src     (rs2),
        .ex      (ex_q),
        .mem     (mem_q),
        .wb      (wb_q),
        .hit_ex  (h2_ex),
        .hit_mem (h2_mem),
        .hit_wb  (h2_wb),
        .fwd     (f2)
    );

`ifdef PIPE_FWD_EN
    // Only a LOAD in EX cannot be forwarded in time: one bubble.
    assign hazard     = (h1_ex | h2_ex) & ex_q.ld;
    assign unused_cfg = ^{h1_mem, h1_wb, h2_mem, h2_wb, mem_q.ld, wb_q.ld,
                          bus.id_instr[RD_LO-1:0]};
`else
    assign hazard     = h1_ex | h1_mem | h1_wb | h2_ex | h2_mem | h2_wb;
    assign unused_cfg = ^{f1, f2, ex_q.ld, mem_q.ld, wb_q.ld, bus.id_instr[RD_LO-1:0]};
`endif

    // Next-state for the EX slot and the operand mux selects.
    always_comb begin
        stall = ~rst & bus.id_valid & hazard;
        issue = bus.id_valid & ~stall;

        ex_d = '0;
        if (issue && writes) begin
            ex_d.v  = 1'b1;
            ex_d.rd = rd;
            ex_d.ld = (op == OP_LD);
        end

        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
`ifdef PIPE_FWD_EN
        if (issue) begin
            fwd_a_d = f1;
            fwd_b_d = f2;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.fwd_a     = fwd_a_q;
    assign bus.fwd_b     = fwd_b_q;
    assign bus.wb_we     = wb_q.v;
    assign bus.wb_rd     = RW'(wb_q.rd);
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances run the same programs:
// u_dut0 with WR_THRU=0, CNT_W=16 and u_dut1 with WR_THRU=1, CNT_W=3
// (small counter so saturation is reachable). Expectations depend on PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RW(4), .CNT_W(16)) bus0 ();
    pipe_hazard_ctrl_if #(.RW(4), .CNT_W(3))  bus1 ();

    pipe_hazard_ctrl #(
        .NREG    (16),
        .RW      (4),
        .WR_THRU (0),
        .CNT_W   (16)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipe_hazard_ctrl #(
        .NREG    (16),
        .RW      (4),
        .WR_THRU (1),
        .CNT_W   (3)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] prog [8];
    int          n;

    // Observed per-DUT results of the last run.
    int fa   [2][8];
    int fb   [2][8];
    int wbrd [2][8];
    int wbn  [2];

    // Expected results, filled in per scenario.
    int ex_fa  [2][8];
    int ex_fb  [2][8];
    int ex_rd  [2][8];
    int ex_wbn [2];
    int ex_st  [2];
    int ex_cnt [2];

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rs1, rs2, rd, 17'd0};
    endfunction

    task automatic drive_idle();
        bus0.id_valid = 1'b0;
        bus0.id_instr = '0;
        bus1.id_valid = 1'b0;
        bus1.id_instr = '0;
    endtask

    task automatic clear_exp();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                ex_fa[d][i] = 0;
                ex_fb[d][i] = 0;
                ex_rd[d][i] = 0;
            end
        end
    endtask

    // Ends on a negedge with rst low; outputs then show the reset state.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_stall0"}, int'(bus0.stall), 0);
        check_eq({tag, "_fwda0"},  int'(bus0.fwd_a), 0);
        check_eq({tag, "_fwdb0"},  int'(bus0.fwd_b), 0);
        check_eq({tag, "_wbwe0"},  int'(bus0.wb_we), 0);
        check_eq({tag, "_wbrd0"},  int'(bus0.wb_rd), 0);
        check_eq({tag, "_cnt0"},   int'(bus0.stall_cnt), 0);
        check_eq({tag, "_wbwe1"},  int'(bus1.wb_we), 0);
        check_eq({tag, "_cnt1"},   int'(bus1.stall_cnt), 0);
    endtask

    // Issue prog[0..n-1] into both DUTs, each honouring its own stall, then drain.
    task automatic run_prog(input string name, input int maxcyc);
        int   pc   [2];
        int   prev [2];
        int   nst  [2];
        logic st   [2];
        for (int d = 0; d < 2; d++) begin
            pc[d]   = 0;
            prev[d] = -1;
            nst[d]  = 0;
            wbn[d]  = 0;
            for (int i = 0; i < 8; i++) begin
                fa[d][i]   = 0;
                fb[d][i]   = 0;
                wbrd[d][i] = 0;
            end
        end
        for (int c = 0; c < maxcyc; c++) begin
            @(negedge clk);
            // fwd selects describe the instruction that entered EX on the last edge.
            if (prev[0] >= 0) begin
                fa[0][prev[0]] = int'(bus0.fwd_a);
                fb[0][prev[0]] = int'(bus0.fwd_b);
            end
            if (prev[1] >= 0) begin
                fa[1][prev[1]] = int'(bus1.fwd_a);
                fb[1][prev[1]] = int'(bus1.fwd_b);
            end
            if (bus0.wb_we) begin
                if (wbn[0] < 8) wbrd[0][wbn[0]] = int'(bus0.wb_rd);
                wbn[0]++;
            end
            if (bus1.wb_we) begin
                if (wbn[1] < 8) wbrd[1][wbn[1]] = int'(bus1.wb_rd);
                wbn[1]++;
            end
            bus0.id_valid = (pc[0] < n);
            bus0.id_instr = (pc[0] < n) ? prog[pc[0]] : '0;
            bus1.id_valid = (pc[1] < n);
            bus1.id_instr = (pc[1] < n) ? prog[pc[1]] : '0;
            #1;
            st[0] = bus0.stall;
            st[1] = bus1.stall;
            for (int d = 0; d < 2; d++) begin
                if (st[d]) nst[d]++;
            end
            if (bus0.id_valid && !st[0]) begin
                prev[0] = pc[0];
                pc[0]++;
            end else begin
                prev[0] = -1;
            end
            if (bus1.id_valid && !st[1]) begin
                prev[1] = pc[1];
                pc[1]++;
            end else begin
                prev[1] = -1;
            end
        end
        drive_idle();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s_d%0d_issued", name, d), pc[d], n);
            check_eq($sformatf("%s_d%0d_stalls", name, d), nst[d], ex_st[d]);
            check_eq($sformatf("%s_d%0d_wbn", name, d), wbn[d], ex_wbn[d]);
            for (int i = 0; i < ex_wbn[d]; i++) begin
                check_eq($sformatf("%s_d%0d_wbrd%0d", name, d, i), wbrd[d][i], ex_rd[d][i]);
            end
            for (int i = 0; i < n; i++) begin
                check_eq($sformatf("%s_d%0d_fwda%0d", name, d, i), fa[d][i], ex_fa[d][i]);
                check_eq($sformatf("%s_d%0d_fwdb%0d", name, d, i), fb[d][i], ex_fb[d][i]);
            end
        end
        check_eq({name, "_d0_cnt"}, int'(bus0.stall_cnt), ex_cnt[0]);
        check_eq({name, "_d1_cnt"}, int'(bus1.stall_cnt), ex_cnt[1]);
    endtask

    initial begin
        int rd1_pulses;
        int pulses;

        drive_idle();
        do_reset();
        check_zero("rst");

        // LD R1,[R2]; ADD R3,R1,R4; SUB R5,R3,R6; ALU R7,R5,R8
        prog[0] = mk(OP_LD,  4'd1, 4'd2, 4'd0);
        prog[1] = mk(OP_ADD, 4'd3, 4'd1, 4'd4);
        prog[2] = mk(OP_SUB, 4'd5, 4'd3, 4'd6);
        prog[3] = mk(OP_ALU, 4'd7, 4'd5, 4'd8);
        n = 4;
        clear_exp();
        ex_wbn = '{4, 4};
        ex_rd[0][0:3] = '{1, 3, 5, 7};
        ex_rd[1][0:3] = '{1, 3, 5, 7};
`ifdef PIPE_FWD_EN
        ex_st  = '{1, 1};
        ex_cnt = '{1, 1};
        ex_fa[0][0:3] = '{0, 2, 1, 1};
        ex_fa[1][0:3] = '{0, 2, 1, 1};
`else
        ex_st  = '{9, 6};
        ex_cnt = '{9, 6};
`endif
        run_prog("chain", 30);

        // Same program again without reset: counters accumulate, 3-bit one saturates.
`ifdef PIPE_FWD_EN
        ex_cnt = '{2, 2};
`else
        ex_cnt = '{18, 7};
`endif
        run_prog("chain2", 30);

        // Independent stream.
        do_reset();
        prog[0] = mk(OP_ADD, 4'd3, 4'd2, 4'd4);
        prog[1] = mk(OP_SUB, 4'd5, 4'd6, 4'd8);
        n = 2;
        clear_exp();
        ex_wbn = '{2, 2};
        ex_rd[0][0:1] = '{3, 5};
        ex_rd[1][0:1] = '{3, 5};
        ex_st  = '{0, 0};
        ex_cnt = '{0, 0};
        run_prog("indep", 12);

        // NOP opcode whose rd (and source fields) name R1, then ADD reading R1.
        do_reset();
        prog[0] = mk(3'b101, 4'd1, 4'd1, 4'd1);
        prog[1] = mk(OP_ADD, 4'd3, 4'd1, 4'd4);
        n = 2;
        clear_exp();
        ex_wbn = '{1, 1};
        ex_rd[0][0] = 3;
        ex_rd[1][0] = 3;
        ex_st  = '{0, 0};
        ex_cnt = '{0, 0};
        run_prog("nop", 12);

        // Producer in MEM feeding operand B.
        do_reset();
        prog[0] = mk(OP_ADD, 4'd1, 4'd2, 4'd4);
        prog[1] = mk(3'b100, 4'd0, 4'd0, 4'd0);
        prog[2] = mk(OP_SUB, 4'd5, 4'd6, 4'd1);
        n = 3;
        clear_exp();
        ex_wbn = '{2, 2};
        ex_rd[0][0:1] = '{1, 5};
        ex_rd[1][0:1] = '{1, 5};
`ifdef PIPE_FWD_EN
        ex_st  = '{0, 0};
        ex_cnt = '{0, 0};
        ex_fb[0][2] = 2;
        ex_fb[1][2] = 2;
`else
        ex_st  = '{2, 1};
        ex_cnt = '{2, 1};
`endif
        run_prog("memb", 16);

        // Producer in WB feeding operand A: only a hazard without write-through.
        do_reset();
        prog[0] = mk(OP_ADD, 4'd1, 4'd2, 4'd4);
        prog[1] = mk(3'b100, 4'd0, 4'd0, 4'd0);
        prog[2] = mk(3'b111, 4'd0, 4'd0, 4'd0);
        prog[3] = mk(OP_SUB, 4'd5, 4'd1, 4'd6);
        n = 4;
        clear_exp();
        ex_wbn = '{2, 2};
        ex_rd[0][0:1] = '{1, 5};
        ex_rd[1][0:1] = '{1, 5};
`ifdef PIPE_FWD_EN
        ex_st  = '{0, 0};
        ex_cnt = '{0, 0};
        ex_fa[0][3] = 3;
`else
        ex_st  = '{1, 0};
        ex_cnt = '{1, 0};
`endif
        run_prog("wba", 16);

        // Reset while a LOAD sits in MEM.
        do_reset();
        bus0.id_valid = 1'b1;
        bus0.id_instr = mk(OP_LD, 4'd1, 4'd2, 4'd0);
        bus1.id_valid = 1'b1;
        bus1.id_instr = mk(OP_LD, 4'd1, 4'd2, 4'd0);
        #1;
        check_eq("mid_ld_stall", int'(bus0.stall), 0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid");
        bus0.id_valid = 1'b1;
        bus0.id_instr = mk(OP_ADD, 4'd3, 4'd1, 4'd4);
        bus1.id_valid = 1'b1;
        bus1.id_instr = mk(OP_ADD, 4'd3, 4'd1, 4'd4);
        #1;
        check_eq("mid_add_stall0", int'(bus0.stall), 0);
        check_eq("mid_add_stall1", int'(bus1.stall), 0);
        rd1_pulses = 0;
        pulses     = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive_idle();
            if (bus0.wb_we) begin
                pulses++;
                if (bus0.wb_rd == 4'd1) rd1_pulses++;
            end
        end
        check_eq("mid_ld_wb", rd1_pulses, 0);
        check_eq("mid_wb_total", pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
